// File: rtl/spi_bank_loader_pkg.sv
// Shared defaults and FSM encoding for the SPI-to-bank loader.
// Keeps the bank geometry and the state encoding in one place for every file that imports it.
package spi_bank_loader_pkg;

    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DATA_DEPTH = 1024;

    // state    | meaning
    // ST_IDLE  | waiting for a chip-select falling edge
    // ST_RECV  | frame open, shifting MOSI bits on sclk rising edges
    // ST_WRITE | one-cycle bank write slot for the completed byte
    // ST_DONE  | one-cycle frame end, load_done pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous pad input.
// RST_VAL is the idle level of the pad, so no false edge is seen coming out of reset.
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_bank_loader.sv
// SPI mode-0 slave that streams received bytes into a bank starting at BASE_ADDR.
// Pads are oversampled by clk; sclk must be at most clk/8.
module spi_bank_loader
    import spi_bank_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  wrenb,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  csen,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   byte_cnt,
    output logic                  overflow
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0]        LAST_BIT  = BCW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    if (BASE_ADDR + DATA_DEPTH - 1 > (1 << ADDR_WIDTH) - 1) begin : g_range_check
        $error("spi_bank_loader: BASE_ADDR + DATA_DEPTH - 1 exceeds address range");
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, cs_fall, cs_rise;

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s));
    spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

    state_t                state, state_nxt;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-2:0] shift;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  done_pend;
    logic [1:0]            settle;
    logic                  settled;
    logic                  frame_start;
    logic                  byte_done;

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;

    // After reset the history registers hold idle levels, not the pad; a cs_n held low
    // through reset would otherwise look like a fresh falling edge.
    assign settled = (settle == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
            settle <= 2'd0;
            state  <= ST_IDLE;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            if (!settled)
                settle <= settle + 2'd1;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        byte_done   = 1'b0;
        csen        = 1'b0;
        busy        = 1'b0;
        load_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                frame_start = cs_fall && settled;
                if (frame_start)
                    state_nxt = ST_RECV;
            end
            ST_RECV: begin
                csen      = 1'b1;
                busy      = 1'b1;
                byte_done = sclk_rise && (bit_cnt == LAST_BIT);
                if (byte_done)
                    state_nxt = ST_WRITE;
                else if (cs_rise)
                    state_nxt = ST_DONE;
            end
            ST_WRITE: begin
                csen      = 1'b1;
                busy      = 1'b1;
                state_nxt = (done_pend || cs_rise) ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            addr_q    <= BASE;
            addr_b    <= BASE;
            data_b    <= '0;
            wrenb     <= 1'b0;
            byte_cnt  <= '0;
            overflow  <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            wrenb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        bit_cnt   <= '0;
                        shift     <= '0;
                        addr_q    <= BASE;
                        byte_cnt  <= '0;
                        overflow  <= 1'b0;
                        done_pend <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (sclk_rise) begin
                        shift   <= {shift[DATA_WIDTH-3:0], mosi_s};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                    if (byte_done) begin
                        done_pend <= cs_rise;
                        if (byte_cnt == DEPTH_CNT) begin
                            overflow <= 1'b1;
                        end else begin
                            wrenb  <= 1'b1;
                            data_b <= {shift, mosi_s};
                            addr_b <= addr_q;
                        end
                    end
                end
                ST_WRITE: begin
                    // wrenb is high exactly in this cycle when the byte was accepted
                    if (wrenb) begin
                        addr_q   <= addr_q + 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    done_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bank_loader.sv
// Directed bench for spi_bank_loader: bit-banged SPI frames with hand-computed expectations.
// A negedge monitor logs every bank write and load_done pulse for later comparison.
module tb_spi_bank_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic [12:0] addr_b;
    logic        wrenb;
    logic [7:0]  data_b;
    logic        csen, busy, load_done;
    logic [13:0] byte_cnt;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          n_wr = 0;
    int          n_done = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always #5 clk = ~clk;

    spi_bank_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .addr_b   (addr_b),
        .wrenb    (wrenb),
        .data_b   (data_b),
        .csen     (csen),
        .busy     (busy),
        .load_done(load_done),
        .byte_cnt (byte_cnt),
        .overflow (overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrenb === 1'b1) begin
            n_wr++;
            last_wr_cyc = cyc;
            wr_addr_q.push_back(32'(addr_b));
            wr_data_q.push_back(32'(data_b));
        end
        if (load_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_wr   = 0;
        n_done = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        wait_clk(4);
        spi_sclk = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic frame_open();
        spi_cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_close();
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(12);
        @(negedge clk);
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_addr_q.size()) begin
            chk({tag, "_addr"}, wr_addr_q[idx], a);
            chk({tag, "_data"}, wr_data_q[idx], d);
        end else begin
            chk({tag, "_present"}, 32'(wr_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr_b"},   32'(addr_b),   32'h0);
        chk({tag, "_data_b"},   32'(data_b),   32'h0);
        chk({tag, "_wrenb"},    32'(wrenb),    32'h0);
        chk({tag, "_csen"},     32'(csen),     32'h0);
        chk({tag, "_busy"},     32'(busy),     32'h0);
        chk({tag, "_done"},     32'(load_done), 32'h0);
        chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'h0);
        chk({tag, "_overflow"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        logic [7:0] b81;
        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(3);
        @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        wait_clk(5);

        // three-byte frame
        clear_log();
        frame_open();
        @(negedge clk);
        chk("f3_busy", 32'(busy), 32'h1);
        chk("f3_csen", 32'(csen), 32'h1);
        spi_byte(8'hA5);
        spi_byte(8'h3C);
        spi_byte(8'hFF);
        frame_close();
        chk("f3_nwr", 32'(n_wr), 32'd3);
        chk_write("f3_w0", 0, 32'd0, 32'hA5);
        chk_write("f3_w1", 1, 32'd1, 32'h3C);
        chk_write("f3_w2", 2, 32'd2, 32'hFF);
        chk("f3_done", 32'(n_done), 32'd1);
        chk("f3_byte_cnt", 32'(byte_cnt), 32'd3);
        chk("f3_overflow", 32'(overflow), 32'h0);
        chk("f3_busy_end", 32'(busy), 32'h0);
        chk("f3_csen_end", 32'(csen), 32'h0);
        chk("f3_addr_hold", 32'(addr_b), 32'd2);
        chk("f3_data_hold", 32'(data_b), 32'hFF);

        // two bytes plus a 5-bit tail that must be dropped
        clear_log();
        frame_open();
        spi_byte(8'h12);
        spi_byte(8'h34);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
        frame_close();
        chk("part_nwr", 32'(n_wr), 32'd2);
        chk_write("part_w0", 0, 32'd0, 32'h12);
        chk_write("part_w1", 1, 32'd1, 32'h34);
        chk("part_done", 32'(n_done), 32'd1);
        chk("part_byte_cnt", 32'(byte_cnt), 32'd2);

        // cs_n rises together with the 8th sclk edge of 0x81
        clear_log();
        b81 = 8'h81;
        frame_open();
        for (int i = 7; i >= 1; i--) spi_bit(b81[i]);
        spi_mosi = b81[0];
        wait_clk(4);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b0;
        wait_clk(12);
        @(negedge clk);
        chk("race_nwr", 32'(n_wr), 32'd1);
        chk_write("race_w0", 0, 32'd0, 32'h81);
        chk("race_done", 32'(n_done), 32'd1);
        chk("race_gap", 32'(done_cyc - last_wr_cyc), 32'd1);
        chk("race_byte_cnt", 32'(byte_cnt), 32'd1);

        // reset in the middle of the first byte, cs_n still held low across it
        clear_log();
        frame_open();
        spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b0);
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(2);
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        rst_n = 1'b1;
        wait_clk(10);
        @(negedge clk);
        chk("mid_rst_nostart", 32'(busy), 32'h0);
        chk("mid_rst_nwr", 32'(n_wr), 32'd0);
        spi_cs_n = 1'b1;
        wait_clk(6);
        frame_open();
        spi_byte(8'h5A);
        frame_close();
        chk("after_rst_nwr", 32'(n_wr), 32'd1);
        chk_write("after_rst_w0", 0, 32'd0, 32'h5A);
        chk("after_rst_byte_cnt", 32'(byte_cnt), 32'd1);

        // 1026 bytes into a 1024-deep bank
        clear_log();
        frame_open();
        for (int i = 0; i < 1026; i++) spi_byte(8'(i));
        frame_close();
        chk("ovf_nwr", 32'(n_wr), 32'd1024);
        chk_write("ovf_first", 0, 32'd0, 32'h00);
        chk_write("ovf_last", 1023, 32'd1023, 32'hFF);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_byte_cnt", 32'(byte_cnt), 32'd1024);
        chk("ovf_done", 32'(n_done), 32'd1);
        chk("ovf_addr_hold", 32'(addr_b), 32'd1023);

        // next frame clears the sticky flag and restarts at the base address
        clear_log();
        frame_open();
        @(negedge clk);
        chk("ovf_clear", 32'(overflow), 32'h0);
        spi_byte(8'h77);
        frame_close();
        chk("ovf_next_nwr", 32'(n_wr), 32'd1);
        chk_write("ovf_next_w0", 0, 32'd0, 32'h77);
        chk("ovf_next_byte_cnt", 32'(byte_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
